round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-round controller for the bell game. Deals card pairs to the judge/score path
//  and runs the reaction countdown that becomes the round's points. Arbitrates P1/P2
//  bell presses from the shared keypad: first edge-detected press wins.
//  Sends a one-cycle 'who' strobe and a frozen 'count' to score_control, then re-deals
//  until the round limit is reached.
// PARAMETERS
//  FLIP_TICKS   50   WAIT cycles before the cards are re-dealt when nobody presses (>=1)
//  WINDOW_MAX   99   count value loaded at each deal (8-bit)
//  RESULT_HOLD  4    cycles spent in HOLD after a press (>=1)
//  MAX_ROUNDS   20   number of decided rounds before game over (8-bit, >=1)
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-low
//  start      in   1   begin or restart the game; honoured only in IDLE or DONE
//  keypad_in  in   4   keypad code: 4'b0111 = P1 bell, 4'b1001 = P2 bell
//  card_rand  in   10  random source {c1[1:0],n1[2:0],c2[1:0],n2[2:0]}
//  c1, c2     out  2   dealt card colours
//  n1, n2     out  3   dealt card numbers, always in 1..5
//  count      out  8   reaction countdown, sampled by score_control
//  who        out  2   01 = P1 pressed, 10 = P2 pressed; one-cycle pulse, else 00
//  round_cnt  out  8   decided rounds so far
//  game_over  out  1   high while in DONE
//  state_dbg  out  3   current state encoding
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE; every output and internal register = 0.
//   key_prev = 4'hF. Reset overrides everything, including mid-round.
//  States (state_dbg): IDLE=0, DEAL=1, WAIT=2, JUDGE=3, HOLD=4, DONE=5.
//  IDLE: start -> DEAL; round_cnt <= 0.
//  DEAL (1 cycle): latch cards from card_rand into c1/n1/c2/n2.
//   Number map per field: 0->1, 1..5 unchanged, 6->3, 7->4.
//   count <= WINDOW_MAX; flip_tmr <= FLIP_TICKS-1; next state is WAIT.
//  Press detect: a press is keypad_in in {0111,1001} with keypad_in != key_prev.
//   key_prev <= keypad_in on every cycle in every state except reset.
//   A held key never re-triggers; a press is only acted on in WAIT.
//  WAIT, cycle k counted from 0: count = WINDOW_MAX-k, saturating at 0;
//   flip_tmr = FLIP_TICKS-1-k.
//   - press: go to JUDGE, freezing count; who <= 01 (P1) or 10 (P2).
//   - no press, flip_tmr==0: go to DEAL. Re-deal period is FLIP_TICKS+1 cycles;
//     round_cnt is unchanged.
//   - otherwise: count decrements unless it is 0; flip_tmr decrements.
//   - press and flip_tmr==0 in the same cycle: the press wins.
//  JUDGE (1 cycle): who is valid only here and count is held. round_cnt +1;
//   hold_tmr <= RESULT_HOLD-1; who returns to 00 on exit; next state is HOLD.
//  HOLD: count and cards are held; presses are ignored. At hold_tmr==0:
//   round_cnt==MAX_ROUNDS -> DONE, else -> DEAL.
//  DONE: game_over=1; all other outputs are held; who=00; start -> DEAL.
//   On that start, round_cnt <= 0 and game_over falls.
//  round_cnt never exceeds MAX_ROUNDS. start outside IDLE/DONE is ignored.
// CONFIGURATION
//  PRESS_LOCKOUT_EN defined:
//   - A press whose cards are wrong locks that player out for the whole next dealt round.
//   - "Wrong" means not (c1==c2 && n1+n2==5) and not (c1!=c2 && (n1==5 || n2==5)),
//     computed internally.
//   - A locked player's presses are ignored in WAIT.
//   - The lock clears at the DEAL that follows the locked round.
//   - It is recorded in a 2-bit lock register, reset 00.
//  PRESS_LOCKOUT_EN undefined: no judging logic; both players are always eligible.
// TESTING
//  1. rst=0 two cycles, all inputs toggling -> every output 0, state_dbg=0.
//  2. start; card_rand={01,010,01,011}; P1 edge at WAIT k=10 ->
//     JUDGE: who=01 for exactly 1 cycle, count=89, round_cnt=1, n1=2, n2=3.
//  3. No press, FLIP_TICKS=50 -> DEAL every 51 cycles; round_cnt stays 0;
//     card_rand field n=7 -> n=4, n=0 -> n=1.
//  4. Hold 0111 from JUDGE through HOLD into the next WAIT -> no second who;
//     release, then press 1001 -> who=10.
//  5. MAX_ROUNDS=2, two presses -> DONE, game_over=1, round_cnt=2; start ->
//     DEAL, round_cnt=0. rst=0 during WAIT -> IDLE next cycle, outputs 0.
//  6. PRESS_LOCKOUT_EN: P1 presses on {00,001,01,010} (wrong) -> next round P1
//     edges ignored and P2 press gives who=10; the round after, P1 accepted again.

Source files
------------

// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//   Game-round controller for the bell game. Deals a pair of cards, runs the
//   reaction countdown, and arbitrates the P1/P2 bell presses from the shared
//   keypad. A new press is a change of keypad code onto one of the two bell
//   codes; a held key does not press again. The winning press produces a
//   one-cycle 'who' strobe and a frozen 'count' for score_control. The block
//   then holds the result and re-deals until the round limit is reached.
//
// Parameters
//   FLIP_TICKS   WAIT cycles before an unanswered deal is replaced (>=1)
//   WINDOW_MAX   countdown value loaded at each deal (8-bit)
//   RESULT_HOLD  cycles spent in HOLD after a press (>=1)
//   MAX_ROUNDS   decided rounds before game over (8-bit, >=1)
//
// Ports
//   clk        in   1   clock
//   rst        in   1   synchronous reset, active low
//   start      in   1   begin/restart the game (acted on in IDLE or DONE only)
//   keypad_in  in   4   keypad code: 4'b0111 = P1 bell, 4'b1001 = P2 bell
//   card_rand  in   10  random source {c1[1:0], n1[2:0], c2[1:0], n2[2:0]}
//   c1, c2     out  2   dealt card colours
//   n1, n2     out  3   dealt card numbers, always 1..5
//   count      out  8   reaction countdown, frozen from the press onwards
//   who        out  2   01 = P1, 10 = P2; one-cycle pulse in JUDGE, else 00
//   round_cnt  out  8   decided rounds so far
//   game_over  out  1   high while in DONE
//   state_dbg  out  3   current state (IDLE=0 DEAL=1 WAIT=2 JUDGE=3 HOLD=4 DONE=5)
//
// Build option
//   PRESS_LOCKOUT_EN  when defined, a press on cards that do not match the
//                     rules locks that player out for the whole next dealt
//                     round. When undefined, both players are always eligible.
// -----------------------------------------------------------------------------
module round_sequencer #(
  parameter int FLIP_TICKS  = 50,
  parameter int WINDOW_MAX  = 99,
  parameter int RESULT_HOLD = 4,
  parameter int MAX_ROUNDS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] keypad_in,
  input  logic [9:0] card_rand,
  output logic [1:0] c1,
  output logic [2:0] n1,
  output logic [1:0] c2,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic [1:0] who,
  output logic [7:0] round_cnt,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  // State encodings
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEAL  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_JUDGE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Keypad codes
  localparam logic [3:0] KEY_P1   = 4'b0111;
  localparam logic [3:0] KEY_P2   = 4'b1001;
  localparam logic [3:0] KEY_NONE = 4'hF;

  // Load values, sized once here
  localparam logic [15:0] FLIP_LOAD   = 16'(FLIP_TICKS - 1);
  localparam logic [15:0] HOLD_LOAD   = 16'(RESULT_HOLD - 1);
  localparam logic [7:0]  COUNT_LOAD  = 8'(WINDOW_MAX);
  localparam logic [7:0]  ROUND_LIMIT = 8'(MAX_ROUNDS);

  // Fold the raw 3-bit number field onto 1..5 (0->1, 6->3, 7->4).
  function automatic logic [2:0] map_num(input logic [2:0] raw);
    logic [2:0] res;
    case (raw)
      3'd0:    res = 3'd1;
      3'd6:    res = 3'd3;
      3'd7:    res = 3'd4;
      default: res = raw;
    endcase
    return res;
  endfunction

`ifdef PRESS_LOCKOUT_EN
  // A press is justified when same-colour cards sum to five, or
  // different-colour cards show a five. Anything else is a wrong press.
  function automatic logic card_wrong(input logic [1:0] a_col, input logic [2:0] a_num,
                                      input logic [1:0] b_col, input logic [2:0] b_num);
    logic [3:0] sum;
    logic       good;
    sum  = {1'b0, a_num} + {1'b0, b_num};
    good = ((a_col == b_col) && (sum == 4'd5)) ||
           ((a_col != b_col) && ((a_num == 3'd5) || (b_num == 3'd5)));
    return !good;
  endfunction
`endif

  // Registers
  logic [2:0]  state_r;
  logic [3:0]  key_prev_r;
  logic [15:0] flip_tmr_r;
  logic [15:0] hold_tmr_r;
  logic [1:0]  c1_r;
  logic [2:0]  n1_r;
  logic [1:0]  c2_r;
  logic [2:0]  n2_r;
  logic [7:0]  count_r;
  logic [1:0]  who_r;
  logic [7:0]  round_cnt_r;
  logic        game_over_r;
`ifdef PRESS_LOCKOUT_EN
  logic [1:0]  lock_r;      // players barred in the current dealt round
  logic [1:0]  lock_pend_r; // wrong presses made this round; become locks at the next deal
`endif

  // Combinational signals
  logic [2:0] next_state_s;
  logic       p1_edge_s;
  logic       p2_edge_s;
  logic       p1_ok_s;
  logic       p2_ok_s;
  logic       press_s;
  logic       wait_press_s;
  logic       new_game_s;

  // Bell press detection: the keypad must move onto a bell code this cycle.
  always_comb begin
    p1_edge_s = (keypad_in == KEY_P1) && (keypad_in != key_prev_r);
    p2_edge_s = (keypad_in == KEY_P2) && (keypad_in != key_prev_r);
`ifdef PRESS_LOCKOUT_EN
    p1_ok_s   = p1_edge_s && !lock_r[0];
    p2_ok_s   = p2_edge_s && !lock_r[1];
`else
    p1_ok_s   = p1_edge_s;
    p2_ok_s   = p2_edge_s;
`endif
    // Only one bell code can be on the keypad at a time, so the two
    // eligible presses are mutually exclusive.
    press_s      = p1_ok_s || p2_ok_s;
    wait_press_s = (state_r == S_WAIT) && press_s;
    new_game_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  end

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_DEAL;
        else       next_state_s = S_IDLE;
      end
      S_DEAL: begin
        next_state_s = S_WAIT;
      end
      S_WAIT: begin
        // A press beats an expiring flip timer in the same cycle.
        if (press_s)                    next_state_s = S_JUDGE;
        else if (flip_tmr_r == 16'd0)   next_state_s = S_DEAL;
        else                            next_state_s = S_WAIT;
      end
      S_JUDGE: begin
        next_state_s = S_HOLD;
      end
      S_HOLD: begin
        if (hold_tmr_r != 16'd0)             next_state_s = S_HOLD;
        else if (round_cnt_r >= ROUND_LIMIT) next_state_s = S_DONE;
        else                                 next_state_s = S_DEAL;
      end
      S_DONE: begin
        if (start) next_state_s = S_DEAL;
        else       next_state_s = S_DONE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= S_IDLE;
    else      state_r <= next_state_s;
  end

  // Keypad history for edge detection, tracked in every state.
  always_ff @(posedge clk) begin
    if (!rst) key_prev_r <= KEY_NONE;
    else      key_prev_r <= keypad_in;
  end

  // Flip timer: loaded at the deal, runs down while nobody presses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flip_tmr_r <= 16'd0;
    end else if (state_r == S_DEAL) begin
      flip_tmr_r <= FLIP_LOAD;
    end else if ((state_r == S_WAIT) && !press_s && (flip_tmr_r != 16'd0)) begin
      flip_tmr_r <= flip_tmr_r - 16'd1;
    end else begin
      flip_tmr_r <= flip_tmr_r;
    end
  end

  // Hold timer: loaded in JUDGE, runs down through HOLD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_tmr_r <= 16'd0;
    end else if (state_r == S_JUDGE) begin
      hold_tmr_r <= HOLD_LOAD;
    end else if ((state_r == S_HOLD) && (hold_tmr_r != 16'd0)) begin
      hold_tmr_r <= hold_tmr_r - 16'd1;
    end else begin
      hold_tmr_r <= hold_tmr_r;
    end
  end

  // Dealt cards: captured only in DEAL, held everywhere else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      c1_r <= 2'd0;
      n1_r <= 3'd0;
      c2_r <= 2'd0;
      n2_r <= 3'd0;
    end else if (state_r == S_DEAL) begin
      c1_r <= card_rand[9:8];
      n1_r <= map_num(card_rand[7:5]);
      c2_r <= card_rand[4:3];
      n2_r <= map_num(card_rand[2:0]);
    end else begin
      c1_r <= c1_r;
      n1_r <= n1_r;
      c2_r <= c2_r;
      n2_r <= n2_r;
    end
  end

  // Reaction countdown: saturates at zero, freezes on a press. The final
  // WAIT cycle before a re-deal leaves it alone because DEAL reloads it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= 8'd0;
    end else if (state_r == S_DEAL) begin
      count_r <= COUNT_LOAD;
    end else if ((state_r == S_WAIT) && !press_s && (flip_tmr_r != 16'd0) &&
                 (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Winner strobe: set on the WAIT->JUDGE step, so it is visible for JUDGE only.
  always_ff @(posedge clk) begin
    if (!rst)              who_r <= 2'b00;
    else if (wait_press_s) who_r <= {p2_ok_s, p1_ok_s};
    else                   who_r <= 2'b00;
  end

  // Decided-round counter: cleared on a new game, bumped with each accepted
  // press. HOLD exits to DONE at the limit, so it never goes past it.
  always_ff @(posedge clk) begin
    if (!rst)              round_cnt_r <= 8'd0;
    else if (new_game_s)   round_cnt_r <= 8'd0;
    else if (wait_press_s) round_cnt_r <= round_cnt_r + 8'd1;
    else                   round_cnt_r <= round_cnt_r;
  end

  // Game-over flag tracks the state being entered so it is high exactly in DONE.
  always_ff @(posedge clk) begin
    if (!rst) game_over_r <= 1'b0;
    else      game_over_r <= (next_state_s == S_DONE);
  end

`ifdef PRESS_LOCKOUT_EN
  // Lockout bookkeeping. A wrong press is parked in lock_pend_r; the next
  // deal promotes it to lock_r for one round and clears the old lock, so a
  // lock lasts exactly one dealt round. A new game drops pending locks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_r      <= 2'b00;
      lock_pend_r <= 2'b00;
    end else if (new_game_s) begin
      lock_r      <= lock_r;
      lock_pend_r <= 2'b00;
    end else if (state_r == S_DEAL) begin
      lock_r      <= lock_pend_r;
      lock_pend_r <= 2'b00;
    end else if (wait_press_s && card_wrong(c1_r, n1_r, c2_r, n2_r)) begin
      lock_r      <= lock_r;
      lock_pend_r <= lock_pend_r | {p2_ok_s, p1_ok_s};
    end else begin
      lock_r      <= lock_r;
      lock_pend_r <= lock_pend_r;
    end
  end
`endif

  // Outputs come straight from registers.
  assign c1        = c1_r;
  assign n1        = n1_r;
  assign c2        = c2_r;
  assign n2        = n2_r;
  assign count     = count_r;
  assign who       = who_r;
  assign round_cnt = round_cnt_r;
  assign game_over = game_over_r;
  assign state_dbg = state_r;

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
//   Directed bench for round_sequencer with FLIP_TICKS=50, WINDOW_MAX=99,
//   RESULT_HOLD=4 and MAX_ROUNDS=3. Inputs are driven 1 time unit after the
//   rising edge and outputs are checked at the same point. Expected values are
//   worked out by hand from the cycle behaviour of the game. The lockout
//   scenario is built only when PRESS_LOCKOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] keypad_in;
  logic [9:0] card_rand;
  logic [1:0] c1;
  logic [2:0] n1;
  logic [1:0] c2;
  logic [2:0] n2;
  logic [7:0] count;
  logic [1:0] who;
  logic [7:0] round_cnt;
  logic       game_over;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] KEY_P1   = 4'b0111;
  localparam logic [3:0] KEY_P2   = 4'b1001;
  localparam logic [3:0] KEY_NONE = 4'hF;

  // {c1, n1, c2, n2}
  localparam logic [9:0] CARD_OK  = {2'b01, 3'b010, 2'b01, 3'b011}; // 2+3 same colour
  localparam logic [9:0] CARD_MAP = {2'b10, 3'd7,   2'b11, 3'd0};   // maps to 4 and 1
  localparam logic [9:0] CARD_BAD = {2'b00, 3'b001, 2'b01, 3'b010}; // wrong cards

  always #5 clk = ~clk;

  round_sequencer #(
    .FLIP_TICKS (50),
    .WINDOW_MAX (99),
    .RESULT_HOLD(4),
    .MAX_ROUNDS (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .keypad_in(keypad_in),
    .card_rand(card_rand),
    .c1       (c1),
    .n1       (n1),
    .c2       (c2),
    .n2       (n2),
    .count    (count),
    .who      (who),
    .round_cnt(round_cnt),
    .game_over(game_over),
    .state_dbg(state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance until the state matches, giving up after a fixed budget.
  task automatic wait_state(input logic [2:0] target, input string tag);
    int n;
    n = 0;
    while ((state_dbg !== target) && (n < 200)) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(state_dbg), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_c1"},    32'(c1),        32'd0);
    check_eq({tag, "_n1"},    32'(n1),        32'd0);
    check_eq({tag, "_c2"},    32'(c2),        32'd0);
    check_eq({tag, "_n2"},    32'(n2),        32'd0);
    check_eq({tag, "_count"}, 32'(count),     32'd0);
    check_eq({tag, "_who"},   32'(who),       32'd0);
    check_eq({tag, "_round"}, 32'(round_cnt), 32'd0);
    check_eq({tag, "_gover"}, 32'(game_over), 32'd0);
    check_eq({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] last_count;

    // ---- reset with inputs toggling ----
    rst = 1'b0; start = 1'b1; keypad_in = KEY_P1; card_rand = 10'h3FF;
    tick();
    start = 1'b0; keypad_in = KEY_P2; card_rand = CARD_OK;
    tick();
    check_all_zero("reset");
    rst = 1'b1; start = 1'b0; keypad_in = KEY_NONE; card_rand = CARD_MAP;
    tick();
    check_eq("idle_stays", 32'(state_dbg), 32'd0);

    // ---- start, number mapping, unanswered re-deal period ----
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_deal", 32'(state_dbg), 32'd1);
    tick();
    check_eq("wait_enter", 32'(state_dbg), 32'd2);
    check_eq("map_c1",     32'(c1),        32'd2);
    check_eq("map_n1_7",   32'(n1),        32'd4);
    check_eq("map_c2",     32'(c2),        32'd3);
    check_eq("map_n2_0",   32'(n2),        32'd1);
    check_eq("count_load", 32'(count),     32'd99);
    card_rand = CARD_OK;
    n = 1;
    last_count = count;
    while ((state_dbg !== 3'd1) && (n < 200)) begin
      last_count = count;
      tick();
      n++;
    end
    check_eq("flip_period",   32'(n),          32'd51);
    check_eq("flip_last_cnt", 32'(last_count), 32'd50);
    check_eq("flip_round",    32'(round_cnt),  32'd0);

    // ---- P1 press at WAIT k=10 ----
    tick();
    check_eq("r1_n1", 32'(n1), 32'd2);
    check_eq("r1_n2", 32'(n2), 32'd3);
    check_eq("r1_c1", 32'(c1), 32'd1);
    repeat (10) tick();
    check_eq("r1_k10_count", 32'(count), 32'd89);
    keypad_in = KEY_P1;
    tick();
    check_eq("r1_judge_state", 32'(state_dbg), 32'd3);
    check_eq("r1_judge_who",   32'(who),       32'd1);
    check_eq("r1_judge_count", 32'(count),     32'd89);
    check_eq("r1_judge_round", 32'(round_cnt), 32'd1);
    tick();
    check_eq("r1_hold_state", 32'(state_dbg), 32'd4);
    check_eq("r1_hold_who",   32'(who),       32'd0);
    check_eq("r1_hold_count", 32'(count),     32'd89);
    repeat (3) tick();
    check_eq("r1_hold_last", 32'(state_dbg), 32'd4);
    tick();
    check_eq("r1_redeal", 32'(state_dbg), 32'd1);

    // ---- held P1 key does not press again ----
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("held_no_press", 32'(state_dbg), 32'd2);
      check_eq("held_no_who",   32'(who),       32'd0);
      tick();
    end
    keypad_in = KEY_NONE;
    tick();
    keypad_in = KEY_P2;
    tick();
    check_eq("r2_judge_state", 32'(state_dbg), 32'd3);
    check_eq("r2_judge_who",   32'(who),       32'd2);
    check_eq("r2_judge_count", 32'(count),     32'd93);
    check_eq("r2_judge_round", 32'(round_cnt), 32'd2);
    keypad_in = KEY_NONE;

    // ---- start ignored mid-game, final round, DONE ----
    wait_state(3'd2, "r3_wait");
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_ignored_state", 32'(state_dbg), 32'd2);
    check_eq("start_ignored_round", 32'(round_cnt), 32'd2);
    keypad_in = KEY_P1;
    tick();
    check_eq("r3_judge_who",   32'(who),       32'd1);
    check_eq("r3_judge_round", 32'(round_cnt), 32'd3);
    keypad_in = KEY_NONE;
    repeat (5) tick();
    check_eq("done_state", 32'(state_dbg), 32'd5);
    check_eq("done_gover", 32'(game_over), 32'd1);
    check_eq("done_round", 32'(round_cnt), 32'd3);
    check_eq("done_who",   32'(who),       32'd0);
    check_eq("done_count", 32'(count),     32'd98);
    check_eq("done_n1",    32'(n1),        32'd2);
    tick();
    check_eq("done_stays", 32'(state_dbg), 32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_state", 32'(state_dbg), 32'd1);
    check_eq("restart_round", 32'(round_cnt), 32'd0);
    check_eq("restart_gover", 32'(game_over), 32'd0);
    tick();
    check_eq("restart_wait", 32'(state_dbg), 32'd2);
    repeat (3) tick();

    // ---- reset in the middle of WAIT ----
    rst = 1'b0; keypad_in = KEY_P1;
    tick();
    check_all_zero("midreset");
    rst = 1'b1; keypad_in = KEY_NONE;
    tick();

`ifdef PRESS_LOCKOUT_EN
    // ---- wrong press locks P1 out for the next round only ----
    card_rand = CARD_BAD;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    keypad_in = KEY_P1;
    tick();
    check_eq("lk_r1_who", 32'(who), 32'd1);
    keypad_in = KEY_NONE;
    card_rand = CARD_OK;
    wait_state(3'd2, "lk_r2_wait");
    keypad_in = KEY_P1;
    tick();
    check_eq("lk_p1_ignored", 32'(state_dbg), 32'd2);
    check_eq("lk_p1_no_who",  32'(who),       32'd0);
    keypad_in = KEY_NONE;
    tick();
    keypad_in = KEY_P1;
    tick();
    check_eq("lk_p1_ignored2", 32'(state_dbg), 32'd2);
    keypad_in = KEY_P2;
    tick();
    check_eq("lk_p2_state", 32'(state_dbg), 32'd3);
    check_eq("lk_p2_who",   32'(who),       32'd2);
    check_eq("lk_p2_round", 32'(round_cnt), 32'd2);
    keypad_in = KEY_NONE;
    wait_state(3'd2, "lk_r3_wait");
    keypad_in = KEY_P1;
    tick();
    check_eq("lk_p1_back_state", 32'(state_dbg), 32'd3);
    check_eq("lk_p1_back_who",   32'(who),       32'd1);
    keypad_in = KEY_NONE;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
